adc_uart_framer: RTL and testbench



---
 rtl/adc_frame_pkg.sv | 28 ++
 rtl/adc_uart_framer_if.sv | 33 +++
 rtl/uart_tx_byte.sv | 102 ++++++++++
 rtl/adc_uart_framer.sv | 123 ++++++++++++
 tb/tb_adc_uart_framer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc_frame_pkg.sv
// Shared types and helpers for the ADC result UART framer.
// Holds the frame geometry, serialiser state encoding and the payload checksum.
package adc_frame_pkg;

    localparam int         FRAME_LEN    = 11;
    localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT = 8'h55;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Index 0 is data_1_H, index 7 is data_4_L.
    typedef logic [7:0][7:0] chan_bytes_t;

    function automatic logic [7:0] frame_checksum(input chan_bytes_t b);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + b[i];
        end
        return sum;
    endfunction

endpackage

// File: rtl/adc_uart_framer_if.sv
// Request/data bundle from the ADC controller plus the framer's line and status outputs.
// master = controller/host side, slave = framer.
interface adc_uart_framer_if;

    logic       frame_req;
    logic [7:0] data_1_H;
    logic [7:0] data_1_L;
    logic [7:0] data_2_H;
    logic [7:0] data_2_L;
    logic [7:0] data_3_H;
    logic [7:0] data_3_L;
    logic [7:0] data_4_H;
    logic [7:0] data_4_L;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] drop_cnt;

    modport master (
        output frame_req,
        output data_1_H, data_1_L, data_2_H, data_2_L,
        output data_3_H, data_3_L, data_4_H, data_4_L,
        input  tx, busy, frame_done, drop_cnt
    );

    modport slave (
        input  frame_req,
        input  data_1_H, data_1_L, data_2_H, data_2_L,
        input  data_3_H, data_3_L, data_4_H, data_4_L,
        output tx, busy, frame_done, drop_cnt
    );

endinterface

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser; start bit drives the line on the edge a byte is accepted.
// in_ready is high when idle or in the last cycle of the stop bit, so bytes chain with no gap.
module uart_tx_byte
    import adc_frame_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       byte_done,
    output logic       tx
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    assign bit_end   = (cnt_q == BAUD_LAST);
    assign byte_done = (state_q == STOP) && bit_end;
    assign in_ready  = (state_q == IDLE) || byte_done;
    assign tx        = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // The shifted register keeps the bit on the line at sh_q[0].
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (in_valid && in_ready) begin
            state_d = START;
            cnt_d   = '0;
            sh_d    = in_data;
            tx_d    = 1'b0;
        end
    end

endmodule

// File: rtl/adc_uart_framer.sv
// Snapshots the four ADC channel results on a request and sends AA 55 <8 bytes> <sum> as UART 8N1.
// Start bit one cycle after acceptance; requests while busy or in the frame_done cycle are dropped and counted.
module adc_uart_framer
    import adc_frame_pkg::*;
#(
    parameter int         BAUD_DIV = 434,
    parameter logic [7:0] HDR0     = HDR0_DEFAULT,
    parameter logic [7:0] HDR1     = HDR1_DEFAULT
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    adc_uart_framer_if.slave   bus
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    chan_bytes_t snap_q, snap_d;
    chan_bytes_t chan_in;
    logic [7:0]  csum_q, csum_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  drop_q, drop_d;

    logic        accept;
    logic        reject;
    logic        more;
    logic [3:0]  next_idx;
    logic [2:0]  sel_idx;
    logic        send_vld;
    logic [7:0]  send_dat;
    logic        ser_rdy;
    logic        ser_done;
    logic        ser_tx;

    assign chan_in = {bus.data_4_L, bus.data_4_H, bus.data_3_L, bus.data_3_H,
                      bus.data_2_L, bus.data_2_H, bus.data_1_L, bus.data_1_H};

    // frame_done cycle still rejects even though busy has already dropped.
    assign accept   = bus.frame_req && !busy_q && !frame_done_q && ser_rdy;
    assign reject   = bus.frame_req && (busy_q || frame_done_q);
    assign more     = busy_q && (idx_q != LAST_IDX);
    assign next_idx = idx_q + 4'd1;
    assign sel_idx  = 3'(next_idx - 4'd2);
    assign send_vld = accept || more;

    always_comb begin
        send_dat = snap_q[sel_idx];
        if (accept) begin
            send_dat = HDR0;
        end else if (next_idx == 4'd1) begin
            send_dat = HDR1;
        end else if (next_idx == LAST_IDX) begin
            send_dat = csum_q;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .in_valid  (send_vld),
        .in_data   (send_dat),
        .in_ready  (ser_rdy),
        .byte_done (ser_done),
        .tx        (ser_tx)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            snap_q       <= '0;
            csum_q       <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            snap_q       <= snap_d;
            csum_q       <= csum_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        snap_d       = snap_q;
        csum_d       = csum_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        drop_d       = drop_q;

        if (accept) begin
            snap_d = chan_in;
            csum_d = frame_checksum(chan_in);
            idx_d  = '0;
            busy_d = 1'b1;
        end

        // Stop-bit end of the byte at idx_q: either chain the next byte or close the frame.
        if (busy_q && ser_done) begin
            if (idx_q == LAST_IDX) begin
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = next_idx;
            end
        end

        if (reject && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign bus.tx         = ser_tx;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_adc_uart_framer.sv
// Bench for adc_uart_framer: table vectors, drop/saturation/reset/snapshot sequences and random frames
// decoded from the tx line against a byte-level frame model.
module tb_adc_uart_framer;

    localparam int B         = 4;
    localparam int FRAME_CYC = 110 * B;
    localparam int TXS_LEN   = FRAME_CYC + 64;

    typedef logic [10:0][7:0] frame_t;
    typedef struct {
        logic [7:0] d [8];
        logic [7:0] exp_cs;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_drop = 0;

    adc_uart_framer_if bif();

    adc_uart_framer #(
        .BAUD_DIV (B),
        .HDR0     (8'hAA),
        .HDR1     (8'h55)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bif)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t model_frame(input logic [7:0] d [8]);
        frame_t f;
        int     sum;
        sum  = 0;
        f[0] = 8'hAA;
        f[1] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            f[2 + i] = d[i];
            sum      = sum + int'(d[i]);
        end
        f[10] = 8'(sum % 256);
        return f;
    endfunction

    task automatic set_data(input logic [7:0] d [8]);
        bif.data_1_H = d[0];
        bif.data_1_L = d[1];
        bif.data_2_H = d[2];
        bif.data_2_L = d[3];
        bif.data_3_H = d[4];
        bif.data_3_L = d[5];
        bif.data_4_H = d[6];
        bif.data_4_L = d[7];
    endtask

    task automatic bump_drop(input int n);
        exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
    endtask

    // Sends one frame, optionally injecting rejected requests at i = a, a+s, ... < b and in the done cycle.
    task automatic run_frame(input string tag, input logic [7:0] d [8], input int cs_exp,
                             input int inj_a, input int inj_b, input int inj_s,
                             input bit inj_done, input bit scramble);
        frame_t     ef;
        logic [7:0] got [11];
        logic [7:0] nd [8];
        bit         txs [TXS_LEN];
        int         done_at;
        int         busy_bad;
        int         inj_n;
        int         frame_bad;
        logic       req;

        ef        = model_frame(d);
        done_at   = -1;
        busy_bad  = 0;
        inj_n     = 0;
        frame_bad = 0;
        foreach (txs[k]) txs[k] = 1'b1;

        @(negedge sys_clk);
        set_data(d);
        bif.frame_req = 1'b1;
        @(negedge sys_clk);
        bif.frame_req = 1'b0;
        check({tag, "_start_lat"}, bif.tx, 0);
        check({tag, "_busy_set"}, bif.busy, 1);

        for (int i = 0; i < TXS_LEN; i++) begin
            txs[i] = bif.tx;
            if (bif.frame_done === 1'b1) begin
                done_at = i;
                break;
            end
            if (bif.busy !== 1'b1) busy_bad++;
            if (i == 0 && scramble) begin
                for (int k = 0; k < 8; k++) nd[k] = ~d[k];
                set_data(nd);
            end
            req = (i >= inj_a) && (i < inj_b) && (((i - inj_a) % inj_s) == 0);
            if (req) inj_n++;
            bif.frame_req = req;
            @(negedge sys_clk);
        end
        bif.frame_req = 1'b0;

        check({tag, "_done_seen"}, done_at >= 0, 1);
        check({tag, "_frame_len"}, done_at, FRAME_CYC);
        check({tag, "_busy_at_done"}, bif.busy, 0);
        check({tag, "_busy_hold"}, busy_bad, 0);

        if (inj_done) begin
            bif.frame_req = 1'b1;
            inj_n++;
            @(negedge sys_clk);
            bif.frame_req = 1'b0;
        end

        for (int k = 0; k < 11; k++) begin
            if (txs[(k * 10) * B + B / 2] !== 1'b0) frame_bad++;
            if (txs[(k * 10 + 9) * B + B / 2] !== 1'b1) frame_bad++;
            for (int j = 0; j < 8; j++) got[k][j] = txs[(k * 10 + 1 + j) * B + B / 2];
        end
        check({tag, "_framing"}, frame_bad, 0);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("%s_byte%0d", tag, k), got[k], ef[k]);
        end
        if (cs_exp >= 0) check({tag, "_cs_table"}, got[10], cs_exp);

        bump_drop(inj_n);
        check({tag, "_drop_cnt"}, bif.drop_cnt, exp_drop);
    endtask

    vec_t       vecs [5];
    logic [7:0] d [8];
    int         activity;

    initial begin
        vecs[0].d = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}; vecs[0].exp_cs = 8'hC0;
        vecs[1].d = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].exp_cs = 8'hF8;
        vecs[2].d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].exp_cs = 8'h00;
        vecs[3].d = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80}; vecs[3].exp_cs = 8'h00;
        vecs[4].d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}; vecs[4].exp_cs = 8'h24;

        sys_rst       = 1'b1;
        bif.frame_req = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = 8'h00;
        set_data(d);
        repeat (3) @(negedge sys_clk);
        check("reset_tx", bif.tx, 1);
        check("reset_busy", bif.busy, 0);
        check("reset_done", bif.frame_done, 0);
        check("reset_drop", bif.drop_cnt, 0);
        sys_rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].d, int'(vecs[v].exp_cs), 0, 0, 1, 1'b0, 1'b0);
        end

        run_frame("drops", vecs[0].d, 8'hC0, 20, 80, 25, 1'b1, 1'b0);
        check("drops_total", bif.drop_cnt, 4);
        run_frame("after_drops", vecs[4].d, 8'h24, 0, 0, 1, 1'b0, 1'b0);

        run_frame("sat", vecs[1].d, 8'hF8, 10, 310, 1, 1'b0, 1'b0);
        check("sat_255", bif.drop_cnt, 255);
        run_frame("sat_hold", vecs[0].d, 8'hC0, 10, 20, 1, 1'b0, 1'b0);

        // Reset during byte 5 of a frame.
        for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
        @(negedge sys_clk);
        set_data(d);
        bif.frame_req = 1'b1;
        @(negedge sys_clk);
        bif.frame_req = 1'b0;
        for (int i = 0; i < 5 * 10 * B + 2 * B; i++) begin
            bif.frame_req = (i == 7);
            @(negedge sys_clk);
        end
        bif.frame_req = 1'b0;
        bump_drop(1);
        check("rst_pre_busy", bif.busy, 1);
        check("rst_pre_drop", bif.drop_cnt, exp_drop);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rst_mid_tx", bif.tx, 1);
        check("rst_mid_busy", bif.busy, 0);
        check("rst_mid_drop", bif.drop_cnt, 0);
        check("rst_mid_done", bif.frame_done, 0);
        sys_rst  = 1'b0;
        exp_drop = 0;
        activity = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sys_clk);
            if (bif.frame_done !== 1'b0 || bif.tx !== 1'b1 || bif.busy !== 1'b0) activity++;
        end
        check("rst_quiet", activity, 0);
        run_frame("post_rst", d, -1, 0, 0, 1, 1'b0, 1'b0);

        run_frame("snapshot", vecs[0].d, 8'hC0, 0, 0, 1, 1'b0, 1'b1);
        run_frame("back2back", vecs[4].d, 8'h24, 0, 0, 1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int a;
            int b;
            int s;
            for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
            a = $urandom_range(5, 100);
            b = a + $urandom_range(0, 150);
            s = $urandom_range(1, 30);
            run_frame($sformatf("rnd%0d", r), d, -1, a, b, s, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
